// File: rtl/vector_addsub_pipe_pkg.sv
// Shared constants for the pipelined vector add/subtract datapath.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Holds the default vector geometry, the operation encodings, and the
// default-width clamp limits. Modules that are re-parametrised derive their
// own limits from their COMP_W.
package vector_addsub_pipe_pkg;

    // Default geometry: three 19-bit signed components (x, y, z) = 57 bits.
    localparam int COMP_W_DEF   = 19;
    localparam int NUM_COMP_DEF = 3;
    localparam int VEC_W        = NUM_COMP_DEF * COMP_W_DEF;

    // Operation select carried on in_op.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Clamp limits for the default component width.
    localparam logic [COMP_W_DEF-1:0] COMP_MAX = {1'b0, {(COMP_W_DEF-1){1'b1}}};
    localparam logic [COMP_W_DEF-1:0] COMP_MIN = {1'b1, {(COMP_W_DEF-1){1'b0}}};

endpackage : vector_addsub_pipe_pkg

// File: rtl/vec_comp_sat.sv
// Narrows one COMP_W+1-bit signed sum to COMP_W bits, clamping or wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, the enclosing stage owns flow control.
//
// Ports:
//   sum_i  [COMP_W:0]    signed full-precision sum/difference of two components
//   res_o  [COMP_W-1:0]  narrowed result
//   ovf_o                set when sum_i does not fit in COMP_W signed bits
module vec_comp_sat #(
    parameter int COMP_W   = 19,
    parameter bit SATURATE = 1'b1
) (
    input  logic [COMP_W:0]   sum_i,
    output logic [COMP_W-1:0] res_o,
    output logic              ovf_o
);

    localparam logic [COMP_W-1:0] LIM_MAX = {1'b0, {(COMP_W-1){1'b1}}};
    localparam logic [COMP_W-1:0] LIM_MIN = {1'b1, {(COMP_W-1){1'b0}}};

    always_comb begin
        // The extra top bit is a copy of the sign whenever the value fits;
        // disagreement means the true result left the COMP_W range.
        ovf_o = sum_i[COMP_W] ^ sum_i[COMP_W-1];
        res_o = sum_i[COMP_W-1:0];
        if (SATURATE && ovf_o) begin
            // The top bit still carries the true sign of the result.
            res_o = sum_i[COMP_W] ? LIM_MIN : LIM_MAX;
        end
    end

endmodule : vec_comp_sat

// File: rtl/vector_addsub_pipe.sv
// Pipelined per-component add/subtract of two packed signed vectors with overflow flags.
// Latency: two cycles from input transfer to out_valid; one vector per cycle sustained.
// Backpressure: valid/ready skid-free pipeline; in_ready drops only when both stages hold data and out_ready=0.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_op                 0 = v1 + v2, 1 = v1 - v2
//   in_vector_1/2         NUM_COMP packed signed components, component 0 in the LSBs
//   out_valid / out_ready output handshake
//   out_vector            packed result, same layout as the inputs
//   out_overflow          bit i set when component i overflowed
module vector_addsub_pipe
    import vector_addsub_pipe_pkg::*;
#(
    parameter int COMP_W   = COMP_W_DEF,
    parameter int NUM_COMP = NUM_COMP_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_op,
    input  logic [NUM_COMP*COMP_W-1:0]   in_vector_1,
    input  logic [NUM_COMP*COMP_W-1:0]   in_vector_2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_COMP*COMP_W-1:0]   out_vector,
    output logic [NUM_COMP-1:0]          out_overflow
);

    localparam int VW  = NUM_COMP * COMP_W;
    localparam int SUM_W = COMP_W + 1;
    localparam int SW  = NUM_COMP * SUM_W;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                s1_valid_q, s1_valid_d;
    logic [SW-1:0]       s1_sum_q,   s1_sum_d;
    logic                s2_valid_q, s2_valid_d;
    logic [VW-1:0]       s2_vec_q,   s2_vec_d;
    logic [NUM_COMP-1:0] s2_ovf_q,   s2_ovf_d;

    logic                s1_accept;
    logic                s2_accept;
    logic                in_xfer;
    logic                s1_move;

    logic [SW-1:0]       new_sum;
    logic [VW-1:0]       nar_vec;
    logic [NUM_COMP-1:0] nar_ovf;

    // ------------------------------------------------------------------
    // Flow control
    // A stage can take new data when it is empty or when its current
    // content leaves in the same cycle. The chain is combinational from
    // out_ready back to in_ready so a full pipe restarts without a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        s2_accept = !s2_valid_q || out_ready;
        s1_accept = !s1_valid_q || s2_accept;
        in_xfer   = in_valid && s1_accept;
        s1_move   = s1_valid_q && s2_accept;
    end

    assign in_ready = s1_accept;

    // ------------------------------------------------------------------
    // Stage 1 arithmetic: sign-extend each component by one bit so the
    // full-precision result always fits; range checking happens in S2.
    // ------------------------------------------------------------------
    always_comb begin
        new_sum = '0;
        for (int i = 0; i < NUM_COMP; i++) begin
            logic [SUM_W-1:0] opa;
            logic [SUM_W-1:0] opb;
            opa = {in_vector_1[i*COMP_W + COMP_W-1], in_vector_1[i*COMP_W +: COMP_W]};
            opb = {in_vector_2[i*COMP_W + COMP_W-1], in_vector_2[i*COMP_W +: COMP_W]};
            if (in_op == OP_SUB) begin
                new_sum[i*SUM_W +: SUM_W] = opa - opb;
            end else begin
                new_sum[i*SUM_W +: SUM_W] = opa + opb;
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        // When the stage frees up it takes whatever is offered, including
        // "nothing", which is how s1_valid clears after a move.
        if (s1_accept) begin
            s1_valid_d = in_valid;
        end
        if (in_xfer) begin
            s1_sum_d = new_sum;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: narrow each component back to COMP_W bits.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_COMP; g++) begin : g_comp
        vec_comp_sat #(
            .COMP_W   (COMP_W),
            .SATURATE (SATURATE)
        ) u_comp_sat (
            .sum_i (s1_sum_q[g*SUM_W +: SUM_W]),
            .res_o (nar_vec[g*COMP_W +: COMP_W]),
            .ovf_o (nar_ovf[g])
        );
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_vec_d   = s2_vec_q;
        s2_ovf_d   = s2_ovf_q;
        // An output transfer with nothing arriving from S1 empties S2;
        // while stalled (out_ready=0) everything holds.
        if (s2_accept) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_move) begin
            s2_vec_d = nar_vec;
            s2_ovf_d = nar_ovf;
        end
    end

    // ------------------------------------------------------------------
    // Registers. Data registers are cleared as well so the outputs read
    // zero after reset; in-flight vectors are discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_vec_q   <= '0;
            s2_ovf_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_vec_q   <= s2_vec_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_vector   = s2_vec_q;
    assign out_overflow = s2_ovf_q;

endmodule : vector_addsub_pipe

// File: tb/tb_vector_addsub_pipe.sv
// Directed bench for vector_addsub_pipe: one saturating and one wrapping instance share stimulus.
// Latency: checks the two-cycle input-to-output path.
// Backpressure: drives a periodic out_ready pattern and checks in_ready against an occupancy model.
module tb_vector_addsub_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_op;
    logic [56:0] v1;
    logic [56:0] v2;
    logic        out_ready;

    logic        in_ready_s,  out_valid_s;
    logic [56:0] out_vec_s;
    logic [2:0]  out_ovf_s;
    logic        in_ready_w,  out_valid_w;
    logic [56:0] out_vec_w;
    logic [2:0]  out_ovf_w;

    int checks   = 0;
    int failures = 0;

    vector_addsub_pipe #(.COMP_W(19), .NUM_COMP(3), .SATURATE(1'b1)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready_s),
        .in_op        (in_op),
        .in_vector_1  (v1),
        .in_vector_2  (v2),
        .out_valid    (out_valid_s),
        .out_ready    (out_ready),
        .out_vector   (out_vec_s),
        .out_overflow (out_ovf_s)
    );

    vector_addsub_pipe #(.COMP_W(19), .NUM_COMP(3), .SATURATE(1'b0)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready_w),
        .in_op        (in_op),
        .in_vector_1  (v1),
        .in_vector_2  (v2),
        .out_valid    (out_valid_w),
        .out_ready    (out_ready),
        .out_vector   (out_vec_w),
        .out_overflow (out_ovf_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [56:0] pk(input int x, input int y, input int z);
        logic [18:0] a, b, c;
        a = x[18:0];
        b = y[18:0];
        c = z[18:0];
        return {c, b, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer with out_ready high; lat counts edges from the
    // start of the drive until out_valid is seen (bounded).
    task automatic single(input logic op, input logic [56:0] a, input logic [56:0] b, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        v1        = a;
        v2        = b;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_s && lat < 20) begin
            step();
            lat++;
        end
    endtask

    logic [56:0] exp_bp [8];
    int          lat;
    int          sent;
    int          rcvd;
    logic        hold_pend;
    logic [56:0] held_vec;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        v1        = '0;
        v2        = '0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_out_valid", out_valid_s, 0);
        check("rst_out_vector", out_vec_s, 0);
        check("rst_out_overflow", out_ovf_s, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready_s, 1);

        // ---------------- 1: basic add ----------------
        single(1'b0, pk(100, -5, 0), pk(23, 10, -7), lat);
        check("add_latency", lat, 2);
        check("add_vec", out_vec_s, pk(123, 5, -7));
        check("add_ovf", out_ovf_s, 3'b000);

        // ---------------- 2: subtract ----------------
        single(1'b1, pk(0, 1000, -262144), pk(1, 1000, 0), lat);
        check("sub_latency", lat, 2);
        check("sub_vec", out_vec_s, pk(-1, 0, -262144));
        check("sub_ovf", out_ovf_s, 3'b000);

        // ---------------- 3/4: positive and negative overflow ----------------
        single(1'b0, pk(262143, 0, 0), pk(1, 0, 0), lat);
        check("sat_pos_vec", out_vec_s, pk(262143, 0, 0));
        check("sat_pos_ovf", out_ovf_s, 3'b001);
        check("wrap_pos_vec", out_vec_w, pk(-262144, 0, 0));
        check("wrap_pos_ovf", out_ovf_w, 3'b001);

        single(1'b1, pk(0, 0, -262144), pk(0, 0, 1), lat);
        check("sat_neg_vec", out_vec_s, pk(0, 0, -262144));
        check("sat_neg_ovf", out_ovf_s, 3'b100);
        check("wrap_neg_vec", out_vec_w, pk(0, 0, 262143));
        check("wrap_neg_ovf", out_ovf_w, 3'b100);

        // drain
        in_valid = 1'b0;
        step();

        // ---------------- 5: backpressure stream ----------------
        // a = (10k, -k, 1000+k), b = (k, 2k, -3); even k add, odd k subtract
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) exp_bp[k] = pk(11 * k, k, 997 + k);
            else            exp_bp[k] = pk(9 * k, -3 * k, 1003 + k);
        end
        sent      = 0;
        rcvd      = 0;
        hold_pend = 1'b0;
        held_vec  = '0;
        for (int cyc = 0; cyc < 200 && rcvd < 8; cyc++) begin
            out_ready = (cyc % 3 == 0);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_op    = sent[0];
                v1       = pk(10 * sent, -sent, 1000 + sent);
                v2       = pk(sent, 2 * sent, -3);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", in_ready_s, !((sent - rcvd) == 2 && !out_ready));
            check("bp_in_ready_wrap", in_ready_w, !((sent - rcvd) == 2 && !out_ready));
            if (hold_pend) begin
                check("bp_hold_valid", out_valid_s, 1);
                check("bp_hold_vec", out_vec_s, held_vec);
            end
            if (out_valid_s && out_ready) begin
                if (rcvd < 8) check("bp_data", out_vec_s, exp_bp[rcvd]);
                rcvd++;
            end
            hold_pend = out_valid_s && !out_ready;
            held_vec  = out_vec_s;
            if (in_valid && in_ready_s) sent++;
            step();
        end
        check("bp_sent", sent, 8);
        check("bp_rcvd", rcvd, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("bp_no_dup", out_valid_s, 0);

        // ---------------- 6: reset mid-stream ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 1'b0;
        v1        = pk(1, 2, 3);
        v2        = pk(4, 5, 6);
        step();
        v1 = pk(7, 7, 7);
        #1;
        check("mid_in_ready_one", in_ready_s, 1);
        step();
        in_valid = 1'b0;
        #1;
        check("mid_full_in_ready", in_ready_s, 0);
        rst = 1'b1;
        step();
        check("mid_rst_out_valid", out_valid_s, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready_s, 1);
        single(1'b0, pk(7, 8, 9), pk(1, 1, 1), lat);
        check("mid_post_latency", lat, 2);
        check("mid_post_vec", out_vec_s, pk(8, 9, 10));
        check("mid_post_ovf", out_ovf_s, 3'b000);
        step();
        check("mid_post_drain", out_valid_s, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vector_addsub_pipe

// File: doc/vector_addsub_pipe.md
Name: vector_addsub_pipe

Overview:
- Parametrised, pipelined successor to the combinational 57-bit vector adder in the ray-tracing datapath.
- Adds or subtracts two packed signed vectors of NUM_COMP components, per transfer. Typical uses are ray origin + offset and hit point − light position.
- Two register stages with valid/ready flow control on both sides; sustained throughput of one vector per cycle.
- Per-component overflow flag; wrap or saturate selected by parameter.

Parameters:
- COMP_W, 19: width of one signed two's-complement component.
- NUM_COMP, 3: number of components per vector (x, y, z).
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap modulo 2^COMP_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept the input this cycle.
- in_op  in  1  0 = add (v1+v2); 1 = subtract (v1−v2).
- in_vector_1  in  NUM_COMP*COMP_W  operand 1; component i occupies bits [i*COMP_W +: COMP_W]; component 0 = x, in the LSBs.
- in_vector_2  in  NUM_COMP*COMP_W  operand 2, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_vector  out  NUM_COMP*COMP_W  result, same packing.
- out_overflow  out  NUM_COMP  bit i set = component i overflowed.

Behaviour:
- Reset, sampled on clk while rst=1:
  - s1_valid=0, s2_valid=0.
  - out_valid=0, out_vector=0, out_overflow=0.
  - in_ready=1 once rst deasserts; reset overrides any transfer in the same cycle.
  - A reset mid-stream drops in-flight data silently.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Stage 1 (S1):
  - Registers per-component COMP_W+1-bit signed results: sign-extend both operands, then add, or subtract the second.
  - Registers s1_valid alongside.
- Stage 2 (S2):
  - Overflow for component i when the top two bits of its COMP_W+1 result differ.
  - SATURATE=1: positive overflow gives 2^(COMP_W−1)−1; negative overflow gives −2^(COMP_W−1).
  - SATURATE=0: the low COMP_W bits pass through.
  - S2 registers the final vector, the overflow flags and s2_valid.
  - out_valid = s2_valid.
- Flow control:
  - s2_accept = !s2_valid | out_ready.
  - s1_accept = !s1_valid | s2_accept.
  - in_ready = s1_accept.
  - S1 moves to S2 when s1_valid & s2_accept.
  - On an output transfer with no S1 move, s2_valid clears.
- Latency and throughput:
  - An input accepted in cycle N appears on out_valid in cycle N+2 when out_ready=1.
  - Full throughput of one transfer per cycle with out_ready held high.
- Simultaneous events:
  - Input transfer, S1→S2 move and output transfer may all happen in the same cycle; no bubble is inserted.
- Backpressure:
  - out_ready=0 with both stages full drives in_ready=0.
  - When out_ready returns high, in_ready rises in the same cycle (combinational path).
  - No data is lost or duplicated.
- Boundaries:
  - −2^(COMP_W−1) − 1 with in_op=1 overflows negative.
  - Each component is independent; no carry between components.
- Storage: 2 entries maximum; no other storage.

Decomposition:
- Shared package: COMP_W/NUM_COMP defaults, VEC_W = NUM_COMP*COMP_W, OP_ADD/OP_SUB encodings, and COMP_MAX/COMP_MIN constants.
- One natural sub-module, vec_comp_sat: combinational COMP_W+1 → COMP_W saturate/wrap with an overflow flag. Instantiate it NUM_COMP times in a generate loop inside S2.

Test Plan:
1. Basic add, out_ready=1: x=100, y=−5, z=0 plus x=23, y=10, z=−7, op=add → result (123, 5, −7) two cycles later, overflow=000.
2. Subtract: x=0, y=1000, z=−262144 minus x=1, y=1000, z=0, op=sub → result (−1, 0, −262144), overflow=000.
3. Saturate, SATURATE=1: x=262143 + 1 → x=262143 with overflow[0]=1; z=−262144 − 1 → z=−262144 with overflow[2]=1.
4. Same stimulus as 3 with SATURATE=0 → x=−262144 and z=262143, same flags.
5. Backpressure:
   - Stream 8 vectors with out_ready toggling 1,0,0,1,…
   - Required: all 8 results in order, none dropped or duplicated.
   - Required: in_ready=0 whenever both stages are full and out_ready=0.
6. Reset mid-stream: assert rst for 1 cycle with 2 vectors in flight → out_valid=0 next cycle, in_ready=1 after rst deasserts, and the next vector yields a correct result.
